pe_fill_arbiter: RTL and testbench

//  Shares one upstream fill stream (global-buffer read port) among NPE PE scratchpad-fill channels (Input or Weight rdy/ack of each PE datapath).

---
 rtl/pe_fill_arbiter.sv | 94 +++++++++
 tb/tb_pe_fill_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_fill_arbiter.sv
// Round-robin arbiter sharing one upstream fill stream among NPE PE scratchpad
// fill channels; a grant stays locked for up to BURST beats before re-arbitration.
module pe_fill_arbiter #(
  parameter  int NPE   = 4,
  parameter  int DW    = 16,
  parameter  int BURST = 8,
  localparam int IW    = $clog2(NPE),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NPE-1:0] i_req,
  input  logic           i_Src_rdy,
  output logic           o_Src_ack,
  input  logic [DW-1:0]  i_Src_data,
  output logic [NPE-1:0] o_Dst_rdy,
  input  logic [NPE-1:0] i_Dst_ack,
  output logic [DW-1:0]  o_Dst_data,
  output logic [NPE-1:0] o_gnt,
  output logic [IW-1:0]  o_gnt_idx,
  output logic           o_busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] probe_idx;
  logic          pick_valid;
  logic          transfer;
  logic          release_gnt;

  // Handshake and data are pure wires: o_gnt is all-zero in IDLE, so no PE sees rdy.
  assign o_busy      = (state == LOCK);
  assign o_Src_ack   = o_busy && i_Dst_ack[o_gnt_idx];
  assign o_Dst_rdy   = o_gnt & {NPE{i_Src_rdy}};
  assign o_Dst_data  = i_Src_data;
  assign transfer    = i_Src_rdy && o_Src_ack;
  assign release_gnt = (transfer && (cnt == CW'(BURST - 1))) ||
                       (!i_req[o_gnt_idx] && !transfer);
  assign next_ptr    = (o_gnt_idx == IW'(NPE - 1)) ? '0 : o_gnt_idx + 1'b1;

  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    probe_idx  = '0;
    for (int k = NPE - 1; k >= 0; k--) begin
      probe_idx = (int'(ptr) + k >= NPE) ? IW'(int'(ptr) + k - NPE) : IW'(int'(ptr) + k);
      if (i_req[probe_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = probe_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (!i_rst) begin
      state     <= IDLE;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
      cnt       <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= LOCK;
            o_gnt     <= NPE'(1) << pick_idx;
            o_gnt_idx <= pick_idx;
            cnt       <= '0;
          end
        end
        LOCK: begin
          if (release_gnt) begin
            state <= IDLE;
            o_gnt <= '0;
            cnt   <= '0;
            ptr   <= next_ptr;
          end else if (transfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fill_arbiter.sv
// Self-checking bench for pe_fill_arbiter: table-driven cycle vectors with a
// beat-data scoreboard, plus hand sequences for round-robin order and mid-burst reset.
module tb_pe_fill_arbiter;

  localparam int NPE   = 4;
  localparam int DW    = 16;
  localparam int BURST = 8;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic [NPE-1:0] i_req = '0;
  logic           i_Src_rdy = 1'b0;
  logic           o_Src_ack;
  logic [DW-1:0]  i_Src_data = '0;
  logic [NPE-1:0] o_Dst_rdy;
  logic [NPE-1:0] i_Dst_ack = '0;
  logic [DW-1:0]  o_Dst_data;
  logic [NPE-1:0] o_gnt;
  logic [1:0]     o_gnt_idx;
  logic           o_busy;

  pe_fill_arbiter #(.NPE(NPE), .DW(DW), .BURST(BURST)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_Src_rdy  (i_Src_rdy),
    .o_Src_ack  (o_Src_ack),
    .i_Src_data (i_Src_data),
    .o_Dst_rdy  (o_Dst_rdy),
    .i_Dst_ack  (i_Dst_ack),
    .o_Dst_data (o_Dst_data),
    .o_gnt      (o_gnt),
    .o_gnt_idx  (o_gnt_idx),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One record per clock cycle: inputs driven after the edge, outputs expected mid-cycle.
  typedef struct {
    string          tag;
    logic           rst;
    logic [NPE-1:0] req;
    logic           rdy;
    logic [NPE-1:0] ack;
    logic [NPE-1:0] gnt;
    logic           src_ack;
  } vec_t;

  vec_t           vecs[$];
  logic [DW-1:0]  data_q[$];
  int             gnt_q[$];

  function automatic void add(input string tag, input logic rst, input logic [NPE-1:0] req,
                              input logic rdy, input logic [NPE-1:0] ack,
                              input logic [NPE-1:0] gnt, input logic src_ack, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.tag = tag; v.rst = rst && (i == 0); v.req = req; v.rdy = rdy;
      v.ack = ack; v.gnt = gnt; v.src_ack = src_ack;
      vecs.push_back(v);
    end
  endfunction

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_req = '0; i_Src_rdy = 1'b0; i_Dst_ack = '0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          v;
    int            exp_idx;
    int            beats;
    int            acks;
    int            e;
    logic          prev_busy;
    logic [DW-1:0] d;

    // Single requester PE2: 8 beats, one idle bubble, re-grant of PE2.
    add("t1", 1, 4'b0100, 1, 4'hF, 4'b0000, 0, 1);
    add("t1", 0, 4'b0100, 1, 4'hF, 4'b0100, 1, 8);
    add("t1", 0, 4'b0100, 1, 4'hF, 4'b0000, 0, 1);
    add("t1", 0, 4'b0100, 1, 4'hF, 4'b0100, 1, 2);
    // PE1 ack stalls 5 cycles mid-burst; others' acks ignored, count frozen.
    add("t3", 1, 4'b0010, 1, 4'hF,    4'b0000, 0, 1);
    add("t3", 0, 4'b0010, 1, 4'hF,    4'b0010, 1, 2);
    add("t3", 0, 4'b0010, 1, 4'b1101, 4'b0010, 0, 5);
    add("t3", 0, 4'b0010, 1, 4'hF,    4'b0010, 1, 6);
    add("t3", 0, 4'b0010, 1, 4'hF,    4'b0000, 0, 1);
    // PE3 drops req after beat 3 with no transfer; pointer wraps to PE0.
    add("t4", 1, 4'b1000, 1, 4'hF,    4'b0000, 0, 1);
    add("t4", 0, 4'b1000, 1, 4'hF,    4'b1000, 1, 3);
    add("t4", 0, 4'b0001, 1, 4'b0000, 4'b1000, 0, 1);
    add("t4", 0, 4'b1001, 1, 4'hF,    4'b0000, 0, 1);
    add("t4", 0, 4'b1001, 1, 4'hF,    4'b0001, 1, 2);
    // Req drops together with a transfer: that beat completes, release next idle cycle.
    add("t4b", 1, 4'b0100, 1, 4'hF,    4'b0000, 0, 1);
    add("t4b", 0, 4'b0100, 1, 4'hF,    4'b0100, 1, 2);
    add("t4b", 0, 4'b0000, 1, 4'hF,    4'b0100, 1, 1);
    add("t4b", 0, 4'b0000, 1, 4'b0000, 4'b0100, 0, 1);
    add("t4b", 0, 4'b0000, 1, 4'hF,    4'b0000, 0, 1);
    // Upstream stall of 20 cycles holds the grant without counting beats.
    add("t5", 1, 4'b0001, 1, 4'hF, 4'b0000, 0, 1);
    add("t5", 0, 4'b0001, 1, 4'hF, 4'b0001, 1, 2);
    add("t5", 0, 4'b0001, 0, 4'hF, 4'b0001, 1, 20);
    add("t5", 0, 4'b0001, 1, 4'hF, 4'b0001, 1, 6);
    add("t5", 0, 4'b0001, 0, 4'hF, 4'b0000, 0, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      if (v.rst) do_reset();
      @(posedge i_clk); #1;
      d = DW'($urandom);
      i_req = v.req; i_Src_rdy = v.rdy; i_Dst_ack = v.ack; i_Src_data = d;
      if (v.src_ack && v.rdy) data_q.push_back(d);
      @(negedge i_clk);
      check($sformatf("%s[%0d] gnt", v.tag, r), 32'(o_gnt), 32'(v.gnt));
      check($sformatf("%s[%0d] busy", v.tag, r), 32'(o_busy), 32'(|v.gnt));
      check($sformatf("%s[%0d] src_ack", v.tag, r), 32'(o_Src_ack), 32'(v.src_ack));
      check($sformatf("%s[%0d] dst_rdy", v.tag, r), 32'(o_Dst_rdy), 32'(v.gnt & {NPE{v.rdy}}));
      if (|v.gnt) begin
        exp_idx = 0;
        for (int b = 0; b < NPE; b++) if (v.gnt[b]) exp_idx = b;
        check($sformatf("%s[%0d] gnt_idx", v.tag, r), 32'(o_gnt_idx), 32'(exp_idx));
      end
      if (o_Src_ack && i_Src_rdy) begin
        if (data_q.size() == 0) check($sformatf("%s[%0d] unexpected beat", v.tag, r), 1, 0);
        else check($sformatf("%s[%0d] data", v.tag, r), 32'(o_Dst_data), 32'(data_q.pop_front()));
      end
    end
    check("sb beats outstanding", data_q.size(), 0);

    // Full-rate contention: grant order 0,1,2,3,0, 8 beats each, ack duty 32/36.
    do_reset();
    check("reset gnt", 32'(o_gnt), 0);
    check("reset gnt_idx", 32'(o_gnt_idx), 0);
    check("reset busy", 32'(o_busy), 0);
    gnt_q = '{0, 1, 2, 3, 0};
    prev_busy = 1'b0; beats = 0; acks = 0;
    for (int c = 0; c < 46; c++) begin
      @(posedge i_clk); #1;
      i_req = 4'hF; i_Src_rdy = 1'b1; i_Dst_ack = 4'hF; i_Src_data = DW'($urandom);
      @(negedge i_clk);
      if (o_busy && !prev_busy) begin
        if (gnt_q.size() == 0) check("t2 extra grant", 1, 0);
        else begin
          e = gnt_q.pop_front();
          check("t2 gnt_idx", 32'(o_gnt_idx), 32'(e));
          check("t2 gnt", 32'(o_gnt), 32'(1) << e);
        end
        beats = 0;
      end
      if (!o_busy && prev_busy) check("t2 burst len", beats, BURST);
      if (o_Src_ack && i_Src_rdy) beats++;
      if (c >= 1 && c <= 36 && o_Src_ack) acks++;
      prev_busy = o_busy;
    end
    check("t2 ack duty", acks, 32);
    check("t2 grants left", gnt_q.size(), 0);

    // Mid-burst async reset: second PE2 burst, reset on beat 4, then PE1 wins from pointer 0.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(posedge i_clk); #1;
      i_req = 4'b0100; i_Src_rdy = 1'b1; i_Dst_ack = 4'hF;
      @(negedge i_clk);
      if (c == 10) check("t6 regrant wraps to PE2", 32'(o_gnt_idx), 2);
    end
    check("t6 busy before reset", 32'(o_busy), 1);
    i_rst = 1'b0; i_req = 4'b1010;
    #1;
    check("t6 reset gnt", 32'(o_gnt), 0);
    check("t6 reset busy", 32'(o_busy), 0);
    check("t6 reset src_ack", 32'(o_Src_ack), 0);
    check("t6 reset dst_rdy", 32'(o_Dst_rdy), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t6 idle after reset", 32'(o_busy), 0);
    @(negedge i_clk);
    check("t6 first grant busy", 32'(o_busy), 1);
    check("t6 first grant idx", 32'(o_gnt_idx), 1);
    check("t6 first grant gnt", 32'(o_gnt), 32'(4'b0010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
